// File: rtl/id_ex_buffer.sv
// rtl/id_ex_buffer.sv - elastic two-entry ID/EX skid register; optional stall counter under ID_EX_STALL_CNT_EN
module id_ex_buffer #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_op1,
   input  logic [DATA_W-1:0]     in_op2,
   input  logic [1:0]            in_alu_mode,
   input  logic [REG_ADDR_W-1:0] in_rdst,
   input  logic                  in_wb_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_op1,
   output logic [DATA_W-1:0]     out_op2,
   output logic [1:0]            out_alu_mode,
   output logic [REG_ADDR_W-1:0] out_rdst,
   output logic                  out_wb_en
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int ENTRY_W = 2*DATA_W + 2 + REG_ADDR_W + 1;

   // Bubble pattern: zero operands, NOP mode, no write-back.
   localparam logic [ENTRY_W-1:0] NOP_ENTRY =
      {{(2*DATA_W){1'b0}}, 2'b11, {REG_ADDR_W{1'b0}}, 1'b0};

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t             state_q, state_nxt;
   logic               in_ready_q, in_ready_nxt;
   logic [ENTRY_W-1:0] main_q, skid_q, in_entry;
   logic               accept, consume;
   logic               load_main_in, load_main_skid, load_skid, clear_main;

   assign in_entry  = {in_op1, in_op2, in_alu_mode, in_rdst, in_wb_en};
   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != S_EMPTY);
   assign accept    = in_valid && in_ready_q;
   assign consume   = out_valid && out_ready;

   // Main register is cleared to the bubble whenever it empties, so the
   // out_* ports read as a NOP without any output muxing.
   assign {out_op1, out_op2, out_alu_mode, out_rdst, out_wb_en} = main_q;

   // Occupancy state and the registered ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_nxt;
         in_ready_q <= in_ready_nxt;
      end
   end

   // Next occupancy and datapath steering; flush overrides every transfer.
   always_comb begin
      state_nxt      = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clear_main     = 1'b0;
      if (flush) begin
         state_nxt  = S_EMPTY;
         clear_main = 1'b1;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_nxt    = S_BUSY;
                  load_main_in = 1'b1;
               end
            end
            S_BUSY: begin
               if (accept && consume) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_nxt = S_FULL;
                  load_skid = 1'b1;
               end else if (consume) begin
                  state_nxt  = S_EMPTY;
                  clear_main = 1'b1;
               end
            end
            S_FULL: begin
               if (consume) begin
                  state_nxt      = S_BUSY;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               state_nxt  = S_EMPTY;
               clear_main = 1'b1;
            end
         endcase
      end
      in_ready_nxt = (state_nxt != S_FULL);
   end

   // Entry storage: main feeds execute, skid absorbs one overflow entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= NOP_ENTRY;
         skid_q <= '0;
      end else begin
         if (clear_main)
            main_q <= NOP_ENTRY;
         else if (load_main_in)
            main_q <= in_entry;
         else if (load_main_skid)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= in_entry;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   // Saturating count of cycles where execute holds off a valid entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= 16'h0000;
      else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_id_ex_buffer.sv
// tb/tb_id_ex_buffer.sv - randomized and directed bench for id_ex_buffer against a queue model
module tb_id_ex_buffer;

   typedef struct packed {
      logic [15:0] op1;
      logic [15:0] op2;
      logic [1:0]  mode;
      logic [2:0]  rdst;
      logic        wb;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_op1, in_op2;
   logic [1:0]  in_alu_mode;
   logic [2:0]  in_rdst;
   logic        in_wb_en;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_op1, out_op2;
   logic [1:0]  out_alu_mode;
   logic [2:0]  out_rdst;
   logic        out_wb_en;
`ifdef ID_EX_STALL_CNT_EN
   logic [15:0] stall_cnt;
   int          m_stall;
`endif

   int tests = 0;
   int fails = 0;

   ent_t q[$];

   id_ex_buffer #(.DATA_W(16), .REG_ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .in_alu_mode(in_alu_mode),
      .in_rdst(in_rdst), .in_wb_en(in_wb_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_alu_mode(out_alu_mode),
      .out_rdst(out_rdst), .out_wb_en(out_wb_en)
`ifdef ID_EX_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of at most two entries; ready means room for one more.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
`ifdef ID_EX_STALL_CNT_EN
         m_stall = 0;
`endif
      end else begin
         bit acc, con;
         ent_t e;
         acc = in_valid && (q.size() < 2);
         con = (q.size() > 0) && out_ready;
`ifdef ID_EX_STALL_CNT_EN
         if ((q.size() > 0) && !out_ready && m_stall < 65535) m_stall++;
`endif
         e = '{in_op1, in_op2, in_alu_mode, in_rdst, in_wb_en};
         if (flush) q.delete();
         else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      ent_t exp;
      exp = (q.size() > 0) ? q[0] : '{16'h0, 16'h0, 2'b11, 3'd0, 1'b0};
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("out_op1", {16'd0, out_op1}, {16'd0, exp.op1});
      chk("out_op2", {16'd0, out_op2}, {16'd0, exp.op2});
      chk("out_alu_mode", {30'd0, out_alu_mode}, {30'd0, exp.mode});
      chk("out_rdst", {29'd0, out_rdst}, {29'd0, exp.rdst});
      chk("out_wb_en", {31'd0, out_wb_en}, {31'd0, exp.wb});
`ifdef ID_EX_STALL_CNT_EN
      chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, input logic [2:0] r, input logic w);
      in_valid = v; in_op1 = a; in_op2 = b; in_alu_mode = m; in_rdst = r; in_wb_en = w;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);
      repeat (2) cyc();
      rst_n = 1'b1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mode", {30'd0, out_alu_mode}, 32'd3);

      // Single transfer
      out_ready = 1'b1;
      drive(1'b1, 16'h0005, 16'h0003, 2'b00, 3'd2, 1'b1);
      cyc();
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_op1", {16'd0, out_op1}, 32'h0005);
      chk("single_op2", {16'd0, out_op2}, 32'h0003);
      chk("single_mode", {30'd0, out_alu_mode}, 32'd0);
      chk("single_rdst", {29'd0, out_rdst}, 32'd2);
      chk("single_wb", {31'd0, out_wb_en}, 32'd1);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);
      cyc();
      chk("single_after_valid", {31'd0, out_valid}, 32'd0);
      chk("single_after_mode", {30'd0, out_alu_mode}, 32'd3);

      // Back-pressure
      out_ready = 1'b0;
      drive(1'b1, 16'h1111, 16'h0, 2'b10, 3'd1, 1'b1);
      cyc();
      chk("bp_ready_a", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 16'h2222, 16'h0, 2'b10, 3'd1, 1'b1);
      cyc();
      chk("bp_ready_b", {31'd0, in_ready}, 32'd0);
      chk("bp_head_a", {16'd0, out_op1}, 32'h1111);
      drive(1'b1, 16'h3333, 16'h0, 2'b10, 3'd1, 1'b1);
      cyc();
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_a", {16'd0, out_op1}, 32'h1111);
      out_ready = 1'b1;
      cyc();
      chk("bp_out_b", {16'd0, out_op1}, 32'h2222);
      cyc();
      chk("bp_out_c", {16'd0, out_op1}, 32'h3333);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);
      cyc();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Streaming
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'(i), 16'h0, 2'b00, 3'(i), 1'b1);
         cyc();
         chk("stream_op1", {16'd0, out_op1}, i);
         chk("stream_ready", {31'd0, in_ready}, 32'd1);
      end
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);
      cyc();

      // Flush while FULL with a pending input
      out_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 16'h0, 2'b01, 3'd4, 1'b1); cyc();
      drive(1'b1, 16'hBBBB, 16'h0, 2'b01, 3'd5, 1'b1); cyc();
      drive(1'b1, 16'hDEAD, 16'h0, 2'b01, 3'd6, 1'b1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);
      out_ready = 1'b1;
      repeat (3) begin
         cyc();
         chk("flush_no_dead", {31'd0, out_op1 == 16'hDEAD}, 32'd0);
      end

      // Asynchronous reset from FULL
      out_ready = 1'b0;
      drive(1'b1, 16'h4444, 16'h1, 2'b00, 3'd1, 1'b1); cyc();
      drive(1'b1, 16'h5555, 16'h2, 2'b00, 3'd2, 1'b1); cyc();
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_mode", {30'd0, out_alu_mode}, 32'd3);
      chk("arst_wb", {31'd0, out_wb_en}, 32'd0);
      chk("arst_op1", {16'd0, out_op1}, 32'd0);
      #1;
      rst_n = 1'b1;
      cyc();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
               2'($urandom), 3'($urandom), 1'($urandom));
         out_ready = $urandom_range(0, 9) < 6;
         flush = $urandom_range(0, 99) < 3;
         cyc();
      end
      flush = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);

`ifdef ID_EX_STALL_CNT_EN
      out_ready = 1'b0;
      drive(1'b1, 16'h7777, 16'h0, 2'b00, 3'd0, 1'b0); cyc();
      drive(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0);
      repeat (70000) cyc();
      chk("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
      cyc();
      chk("stall_hold", {16'd0, stall_cnt}, 32'hFFFF);
      flush = 1'b1; cyc(); flush = 1'b0; cyc();
      chk("stall_flush", {16'd0, stall_cnt}, 32'hFFFF);
`endif

      out_ready = 1'b1;
      repeat (3) cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
